wishbone_button_ctrl: RTL and testbench

Parametrised WISHBONE slave for push-button inputs, replacing the fixed 4-bit GPIO button wrapper. It synchronises and debounces NUM_BUTTONS raw inputs and exposes the debounced state. It detects press (and optionally release) edges into sticky write-1-to-clear status bits and drives a level interrupt. It sits on the peripheral WISHBONE bus alongside the other GPIO slaves.

---
 rtl/wishbone_button_ctrl.sv | 128 ++++++++++++
 tb/tb_wishbone_button_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_button_ctrl.sv
// WISHBONE slave for NUM_BUTTONS push-buttons: 2-flop sync, counter debounce, sticky edge status, level IRQ.
// Every access is acked one cycle after the request, so back-to-back strobes complete every other cycle.
module wishbone_button_ctrl #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            adr_i,
  input  logic [31:0]            dat_i,
  output logic [31:0]            dat_o,
  input  logic                   we_i,
  input  logic [3:0]             sel_i,
  input  logic                   stb_i,
  input  logic                   cyc_i,
  output logic                   ack_o,
  input  logic [NUM_BUTTONS-1:0] gpio_buttons,
  output logic                   irq_o
);

  localparam int N  = NUM_BUTTONS;
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_IRQ_EN = 2'd1,
    REG_STATUS = 2'd2,
    REG_EDGE   = 2'd3
  } reg_sel_e;

  logic [N-1:0]         pressed;
  logic [N-1:0]         s1_q, s2_q;
  logic [N-1:0]         db_q, db_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]         irq_en_q, irq_en_d;
  logic [N-1:0]         edge_both_q, edge_both_d;
  logic [N-1:0]         status_q, status_d;
  logic [N-1:0]         set_ev, clr, wmask, wdat;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d, rdata;
  logic                 req, wr_en;
  reg_sel_e             reg_sel;
  logic                 unused_bits;

  assign pressed     = (ACTIVE_LOW != 0) ? ~gpio_buttons : gpio_buttons;
  assign reg_sel     = reg_sel_e'(adr_i[3:2]);
  assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i, sel_i};

  // A sample that disagrees with db for DEBOUNCE_CYCLES consecutive edges is accepted.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    set_ev = (db_d & ~db_q) | (~db_d & db_q & edge_both_q);
  end

  always_comb begin
    req         = cyc_i & stb_i & ~ack_q;
    wr_en       = req & we_i;
    wmask       = '0;
    for (int i = 0; i < N; i++) wmask[i] = sel_i[i/8];
    wdat        = dat_i[N-1:0] & wmask;
    irq_en_d    = irq_en_q;
    edge_both_d = edge_both_q;
    clr         = '0;
    rdata       = '0;
    unique case (reg_sel)
      REG_DATA:   rdata[N-1:0] = db_q;
      REG_IRQ_EN: begin
        rdata[N-1:0] = irq_en_q;
        if (wr_en) irq_en_d = (irq_en_q & ~wmask) | wdat;
      end
      REG_STATUS: begin
        rdata[N-1:0] = status_q;
        if (wr_en) clr = wdat;
      end
      REG_EDGE:   begin
        rdata[N-1:0] = edge_both_q;
        if (wr_en) edge_both_d = (edge_both_q & ~wmask) | wdat;
      end
      default:    rdata = '0;
    endcase
    // Set has priority over a same-cycle write-1-to-clear.
    status_d = (status_q & ~clr) | set_ev;
    ack_d    = req;
    dat_d    = req ? rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      db_q        <= '0;
      cnt_q       <= '0;
      irq_en_q    <= '0;
      edge_both_q <= '0;
      status_q    <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      s1_q        <= pressed;
      s2_q        <= s1_q;
      db_q        <= db_d;
      cnt_q       <= cnt_d;
      irq_en_q    <= irq_en_d;
      edge_both_q <= edge_both_d;
      status_q    <= status_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = |(status_q & irq_en_q);

endmodule

// File: tb/tb_wishbone_button_ctrl.sv
// Directed bench: register-access vector table plus hand-timed debounce, W1C and handshake sequences.
module tb_wishbone_button_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_w;
  logic        we, stb, cyc_a, cyc_b;
  logic [3:0]  sel;
  logic [31:0] dat_o_a, dat_o_b;
  logic        ack_a, ack_b, irq_a, irq_b;
  logic [3:0]  gpio_a;
  logic [31:0] gpio_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wishbone_button_ctrl #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(16), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_o_a), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc_a), .ack_o(ack_a), .gpio_buttons(gpio_a), .irq_o(irq_a)
  );

  wishbone_button_ctrl #(.NUM_BUTTONS(32), .DEBOUNCE_CYCLES(16), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_o_b), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc_b), .ack_o(ack_b), .gpio_buttons(gpio_b), .irq_o(irq_b)
  );

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic [31:0] exp;
    bit          irq;
  } vec_t;

  vec_t vt[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // One WISHBONE access; b selects the 32-button instance.
  task automatic wb_acc(input bit b, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd);
    @(negedge clk);
    adr = a; dat_w = wd; we = w; sel = s; stb = 1'b1;
    cyc_a = ~b; cyc_b = b;
    @(posedge clk);
    @(negedge clk);
    check("ack_high", {31'b0, b ? ack_b : ack_a}, 32'd1);
    rd = b ? dat_o_b : dat_o_a;
    stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ack_low", {31'b0, b ? ack_b : ack_a}, 32'd0);
    check("dat_o_idle", b ? dat_o_b : dat_o_a, 32'd0);
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_acc(1'b0, 1'b1, a, wd, 4'hF, dummy);
  endtask

  task automatic rd_chk(input bit b, input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    wb_acc(b, 1'b0, a, 32'd0, 4'hF, rd);
    check(nm, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    vt[0]  = '{0, 32'h0, 32'h0,        4'hF, 32'h0, 0};
    vt[1]  = '{0, 32'h4, 32'h0,        4'hF, 32'h0, 0};
    vt[2]  = '{0, 32'h8, 32'h0,        4'hF, 32'h0, 0};
    vt[3]  = '{0, 32'hC, 32'h0,        4'hF, 32'h0, 0};
    vt[4]  = '{1, 32'h4, 32'hFFFFFFFF, 4'hF, 32'h0, 0};
    vt[5]  = '{0, 32'h4, 32'h0,        4'hF, 32'hF, 0};
    vt[6]  = '{1, 32'h4, 32'h0,        4'h0, 32'h0, 0};
    vt[7]  = '{0, 32'h4, 32'h0,        4'hF, 32'hF, 0};
    vt[8]  = '{1, 32'h4, 32'h4,        4'h1, 32'h0, 0};
    vt[9]  = '{0, 32'h4, 32'h0,        4'hF, 32'h4, 0};
    vt[10] = '{1, 32'hC, 32'hF,        4'h1, 32'h0, 0};
    vt[11] = '{0, 32'hC, 32'h0,        4'hF, 32'hF, 0};
    vt[12] = '{1, 32'hC, 32'h0,        4'hF, 32'h0, 0};
    vt[13] = '{0, 32'hC, 32'h0,        4'hF, 32'h0, 0};
    vt[14] = '{1, 32'h0, 32'hF,        4'hF, 32'h0, 0};
    vt[15] = '{0, 32'h0, 32'h0,        4'hF, 32'h0, 0};
    vt[16] = '{1, 32'h8, 32'hF,        4'hF, 32'h0, 0};
    vt[17] = '{0, 32'h8, 32'h0,        4'hF, 32'h0, 0};

    rst = 1'b1; adr = '0; dat_w = '0; we = 1'b0; sel = '0; stb = 1'b0;
    cyc_a = 1'b0; cyc_b = 1'b0; gpio_a = '0; gpio_b = '1;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'b0, ack_a}, 32'd0);
    check("rst_irq", {31'b0, irq_a}, 32'd0);
    check("rst_dat_o", dat_o_a, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      wb_acc(1'b0, vt[i].we, vt[i].adr, vt[i].wd, vt[i].sel, rd);
      if (!vt[i].we) check($sformatf("vec%0d_rd", i), rd, vt[i].exp);
      check($sformatf("vec%0d_irq", i), {31'b0, irq_a}, {31'b0, vt[i].irq});
    end

    // Press bit2 (IRQ_EN=0x4): db and irq rise on the 18th edge counting E0.
    @(negedge clk); gpio_a[2] = 1'b1;
    repeat (17) @(posedge clk);
    @(negedge clk); check("press_irq_early", {31'b0, irq_a}, 32'd0);
    @(posedge clk);
    @(negedge clk); check("press_irq_on", {31'b0, irq_a}, 32'd1);
    rd_chk(0, 32'h0, 32'h4, "press_data");
    rd_chk(0, 32'h8, 32'h4, "press_status");
    wr_a(32'h8, 32'h4);
    check("w1c_irq_off", {31'b0, irq_a}, 32'd0);
    wr_a(32'h4, 32'h1);

    // Bounce bit0: high 10, low 3, then stable high.
    @(negedge clk); gpio_a[0] = 1'b1;
    repeat (10) @(negedge clk); gpio_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("bounce_irq_mid", {31'b0, irq_a}, 32'd0);
    gpio_a[0] = 1'b1;
    repeat (17) @(posedge clk);
    @(negedge clk); check("bounce_irq_early", {31'b0, irq_a}, 32'd0);
    @(posedge clk);
    @(negedge clk); check("bounce_irq_on", {31'b0, irq_a}, 32'd1);
    rd_chk(0, 32'h8, 32'h1, "bounce_status");
    rd_chk(0, 32'h0, 32'h5, "bounce_data");

    // Release bit2 with EDGE_BOTH=0: no status change.
    @(negedge clk); gpio_a[2] = 1'b0;
    repeat (25) @(negedge clk);
    rd_chk(0, 32'h8, 32'h1, "rel_noedge_status");
    rd_chk(0, 32'h0, 32'h1, "rel_noedge_data");

    // Release bit0 with EDGE_BOTH=0x1: falling edge sets status.
    wr_a(32'h8, 32'h1);
    rd_chk(0, 32'h8, 32'h0, "w1c_bit0");
    check("w1c_bit0_irq", {31'b0, irq_a}, 32'd0);
    wr_a(32'hC, 32'h1);
    @(negedge clk); gpio_a[0] = 1'b0;
    repeat (25) @(negedge clk);
    rd_chk(0, 32'h8, 32'h1, "rel_both_status");
    check("rel_both_irq", {31'b0, irq_a}, 32'd1);
    rd_chk(0, 32'h0, 32'h0, "rel_both_data");

    // STATUS=0x5, clear bit0 -> 0x4; irq follows IRQ_EN.
    @(negedge clk); gpio_a[2] = 1'b1;
    repeat (25) @(negedge clk);
    rd_chk(0, 32'h8, 32'h5, "status_5");
    wr_a(32'h8, 32'h1);
    rd_chk(0, 32'h8, 32'h4, "status_4");
    check("irq_en1_status4", {31'b0, irq_a}, 32'd0);
    wr_a(32'h4, 32'h4);
    check("irq_en4_status4", {31'b0, irq_a}, 32'd1);

    // W1C of bit1 on the same edge its press lands: set wins.
    @(negedge clk); gpio_a[1] = 1'b1;
    repeat (17) @(posedge clk);
    wr_a(32'h8, 32'h2);
    rd_chk(0, 32'h8, 32'h6, "set_wins");

    // Strobe without cycle: no ack, no write.
    @(negedge clk); adr = 32'h4; dat_w = 32'hF; we = 1'b1; sel = 4'hF; stb = 1'b1;
    repeat (2) @(negedge clk);
    check("stb_nocyc_ack", {31'b0, ack_a}, 32'd0);
    stb = 1'b0; we = 1'b0;
    rd_chk(0, 32'h4, 32'h4, "stb_nocyc_irq_en");

    // Held strobe is acked every other cycle.
    @(negedge clk); adr = 32'h0; we = 1'b0; stb = 1'b1; cyc_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack%0d", i), {31'b0, ack_a}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    stb = 1'b0; cyc_a = 1'b0;

    // 32 active-low buttons.
    rd_chk(1, 32'h0, 32'h0, "al_idle_data");
    wb_acc(1'b1, 1'b1, 32'h4, 32'hFFFFFFFF, 4'b0010, rd);
    rd_chk(1, 32'h4, 32'h0000FF00, "al_irq_en_lane1");
    @(negedge clk); gpio_b[31] = 1'b0;
    repeat (25) @(negedge clk);
    rd_chk(1, 32'h0, 32'h80000000, "al_press31_data");
    rd_chk(1, 32'h8, 32'h80000000, "al_press31_status");
    check("al_irq_masked", {31'b0, irq_b}, 32'd0);

    // Asynchronous reset clears state without a clock edge.
    @(negedge clk);
    check("pre_rst_irq", {31'b0, irq_a}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_irq", {31'b0, irq_a}, 32'd0);
    @(negedge clk); rst = 1'b0;
    rd_chk(0, 32'h8, 32'h0, "post_rst_status");
    rd_chk(0, 32'h4, 32'h0, "post_rst_irq_en");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
